// File: rtl/axi_cache_pkg.sv
// Shared types and constants for the cache AXI front ends.
package axi_cache_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat-address stepper: current beat address -> next beat address.
module axi_burst_addr_gen
  import axi_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  burst_t                burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] wrap_lo;

  // Step to the next size-aligned beat; WRAP folds back to the bottom of its window.
  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size;
    aligned    = cur_addr & ~(beat_bytes - ADDR_WIDTH'(1));
    incr_addr  = aligned + beat_bytes;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_lo    = cur_addr & ~(wrap_bytes - ADDR_WIDTH'(1));
    case (burst)
      FIXED:   next_addr = cur_addr;
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (incr_addr == wrap_lo + wrap_bytes) ? wrap_lo : incr_addr;
      default: next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_ingress.sv
// AXI4 slave write front end: joins AW and W, splits bursts into per-beat FIFO pushes,
// and returns one B response per burst. Single burst outstanding.
module axi_wr_ingress
  import axi_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  localparam int unsigned STRB_W    = DATA_WIDTH / 8,
  localparam int unsigned MAX_SIZE  = $clog2(STRB_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [1:0]            s_awburst,
  input  logic [2:0]            s_awsize,
  input  logic [7:0]            s_awlen,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_W-1:0]     s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ADDR_WIDTH-1:0] push_addr,
  output logic [ID_WIDTH-1:0]   push_id,
  output logic [1:0]            push_burst,
  output logic [2:0]            push_size,
  output logic [7:0]            push_len,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic [STRB_W-1:0]     push_strb,
  output logic                  push_valid,
  input  logic                  push_ready
);

  state_t                state_q, state_d;
  logic                  awready_q;
  logic [ID_WIDTH-1:0]   id_q;
  burst_t                burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beat_cnt_q;
  logic                  err_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic aw_hs;
  logic aw_err;
  logic beat_hs;
  logic last_beat;
  logic wlast_bad;

  assign aw_hs     = s_awvalid & awready_q;
  assign aw_err    = (s_awburst == RSVD) || (s_awsize > 3'(MAX_SIZE)) ||
                     ((s_awburst == WRAP) && !wrap_len_ok(s_awlen));
  assign beat_hs   = (state_q == DATA) && s_wvalid && s_wready;
  assign last_beat = (beat_cnt_q == len_q);
  // Burst length comes from awlen; wlast is only checked, never trusted.
  assign wlast_bad = (s_wlast != last_beat);

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .cur_addr  (addr_q),
    .burst     (burst_q),
    .size      (size_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (beat_hs && last_beat) state_d = RESP;
      RESP:    if (s_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; errored bursts are drained without touching the FIFO.
  always_comb begin
    s_wready   = 1'b0;
    push_valid = 1'b0;
    s_bvalid   = 1'b0;
    case (state_q)
      DATA: begin
        if (err_q) begin
          s_wready = 1'b1;
        end else begin
          s_wready   = push_ready;
          push_valid = s_wvalid;
        end
      end
      RESP:    s_bvalid = 1'b1;
      default: ;
    endcase
  end

  // AW ready is registered: high in every cycle that follows a cycle ending in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
    end else begin
      awready_q <= (state_d == IDLE);
    end
  end

  // Burst context: latched on AW, advanced per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      burst_q    <= FIXED;
      size_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (aw_hs) begin
      id_q       <= s_awid;
      burst_q    <= burst_t'(s_awburst);
      size_q     <= s_awsize;
      len_q      <= s_awlen;
      addr_q     <= s_awaddr;
      beat_cnt_q <= '0;
      err_q      <= aw_err;
    end else if (beat_hs) begin
      beat_cnt_q <= beat_cnt_q + 8'd1;
      addr_q     <= next_addr;
      if (wlast_bad) err_q <= 1'b1;
      if (last_beat) bresp_q <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_awready  = awready_q;
  assign s_bid      = id_q;
  assign s_bresp    = bresp_q;
  assign push_addr  = addr_q;
  assign push_id    = id_q;
  assign push_burst = burst_q;
  assign push_size  = size_q;
  assign push_len   = len_q;
  assign push_data  = s_wdata;
  assign push_strb  = s_wstrb;

endmodule
